ppu_row_scheduler: RTL and testbench

Sequences the per-row rendering pipeline inside the PPU logic. It starts the background-fetch and sprite-fetch engines for each of the 240 display rows, then starts the pixel mixer once both fetches finish, and parks until the HDMI side swaps row RAMs. It sits between the PPU frame FSM (vblank_start/vblank_end, gated rowram_swap) and the row-render datapath. It also reports rows that miss their swap deadline.

---
 rtl/ppu_row_scheduler.sv | 160 ++++++++++++++++
 tb/tb_ppu_row_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ppu_row_scheduler.sv
// Per-row render sequencer: kicks bg/sprite fetch, then the mixer, then waits for
// the HDMI row-RAM swap before advancing; tracks rows that miss their swap.
module ppu_row_scheduler #(
  parameter int NUM_ROWS = 240,
  parameter int LATE_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              vblank_start_i,
  input  logic              vblank_end_i,
  input  logic              rowram_swap_i,
  input  logic              bg_done_i,
  input  logic              spr_done_i,
  input  logic              pix_done_i,
  output logic              bg_start_o,
  output logic              spr_start_o,
  output logic              pix_start_o,
  output logic              stage_abort_o,
  output logic [7:0]        row_num_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              frame_late_o,
  output logic [LATE_W-1:0] late_count_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_MIX, S_WAIT} state_e;

  state_e              state_q, state_d;
  logic [7:0]          row_q, row_d;
  logic                bg_ok_q, bg_ok_d, spr_ok_q, spr_ok_d, pend_q, pend_d;
  logic                late_q, late_d;
  logic [LATE_W-1:0]   lcnt_q, lcnt_d;
  logic                start_q, start_d, pix_q, pix_d, abort_q, abort_d;
  logic                fdone_q, fdone_d, busy_q, busy_d;
  logic                adv, late_ev;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    bg_ok_d  = bg_ok_q;
    spr_ok_d = spr_ok_q;
    pend_d   = pend_q;
    late_d   = late_q;
    lcnt_d   = lcnt_q;
    start_d  = 1'b0;
    pix_d    = 1'b0;
    abort_d  = 1'b0;
    fdone_d  = 1'b0;
    adv      = 1'b0;
    late_ev  = 1'b0;
    case (state_q)
      S_IDLE: if (vblank_end_i) begin
        state_d = S_FETCH;
        row_d   = 8'd0;
        start_d = 1'b1;
        late_d  = 1'b0;
        lcnt_d  = '0;
        pend_d  = 1'b0;
      end
      S_FETCH: begin
        late_ev  = rowram_swap_i;
        bg_ok_d  = bg_ok_q | bg_done_i;
        spr_ok_d = spr_ok_q | spr_done_i;
        if (bg_ok_d && spr_ok_d) begin
          state_d  = S_MIX;
          pix_d    = 1'b1;
          bg_ok_d  = 1'b0;
          spr_ok_d = 1'b0;
        end
      end
      S_MIX: begin
        if (pix_done_i) begin
          if (pend_q || rowram_swap_i) adv = 1'b1;
          else state_d = S_WAIT;
        end else begin
          late_ev = rowram_swap_i;
        end
      end
      S_WAIT:  adv = rowram_swap_i;
      default: state_d = S_IDLE;
    endcase

    // An early swap is remembered once; repeats only bump the counter.
    if (late_ev) begin
      pend_d = 1'b1;
      late_d = 1'b1;
      if (lcnt_q != '1) lcnt_d = lcnt_q + LATE_W'(1);
    end

    if (adv) begin
      pend_d = 1'b0;
      if (row_q < 8'(NUM_ROWS - 1)) begin
        row_d   = row_q + 8'd1;
        state_d = S_FETCH;
        start_d = 1'b1;
      end else begin
        fdone_d = 1'b1;
        state_d = S_IDLE;
      end
    end

    // vblank_start overrides everything else seen this cycle.
    if (state_q != S_IDLE && vblank_start_i) begin
      state_d  = S_IDLE;
      abort_d  = 1'b1;
      row_d    = row_q;
      bg_ok_d  = 1'b0;
      spr_ok_d = 1'b0;
      pend_d   = 1'b0;
      late_d   = late_q;
      lcnt_d   = lcnt_q;
      start_d  = 1'b0;
      pix_d    = 1'b0;
      fdone_d  = 1'b0;
    end

    busy_d = (state_d == S_FETCH) || (state_d == S_MIX);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      row_q    <= 8'd0;
      bg_ok_q  <= 1'b0;
      spr_ok_q <= 1'b0;
      pend_q   <= 1'b0;
      late_q   <= 1'b0;
      lcnt_q   <= '0;
      start_q  <= 1'b0;
      pix_q    <= 1'b0;
      abort_q  <= 1'b0;
      fdone_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      bg_ok_q  <= bg_ok_d;
      spr_ok_q <= spr_ok_d;
      pend_q   <= pend_d;
      late_q   <= late_d;
      lcnt_q   <= lcnt_d;
      start_q  <= start_d;
      pix_q    <= pix_d;
      abort_q  <= abort_d;
      fdone_q  <= fdone_d;
      busy_q   <= busy_d;
    end
  end

  assign bg_start_o    = start_q;
  assign spr_start_o   = start_q;
  assign pix_start_o   = pix_q;
  assign stage_abort_o = abort_q;
  assign row_num_o     = row_q;
  assign busy_o        = busy_q;
  assign frame_done_o  = fdone_q;
  assign frame_late_o  = late_q;
  assign late_count_o  = lcnt_q;

endmodule

// File: tb/tb_ppu_row_scheduler.sv
// Randomized row-timing bench; expected events are computed per row from event
// times and pushed to a queue, a negedge monitor pops and compares them.
module tb_ppu_row_scheduler;
  logic clk = 1'b0, rst = 1'b1;
  logic vbs = 1'b0, vbe = 1'b0, swp = 1'b0, bgd = 1'b0, sprd = 1'b0, pixd = 1'b0;
  logic bg_start, spr_start, pix_start, stage_abort, busy, frame_done, frame_late;
  logic [7:0] row_num, late_count;

  ppu_row_scheduler #(.NUM_ROWS(240), .LATE_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .vblank_start_i(vbs), .vblank_end_i(vbe),
    .rowram_swap_i(swp), .bg_done_i(bgd), .spr_done_i(sprd), .pix_done_i(pixd),
    .bg_start_o(bg_start), .spr_start_o(spr_start), .pix_start_o(pix_start),
    .stage_abort_o(stage_abort), .row_num_o(row_num), .busy_o(busy),
    .frame_done_o(frame_done), .frame_late_o(frame_late), .late_count_o(late_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc; logic [4:0] pul; int row; logic busy; int lc; logic fl;
  } exp_t;
  exp_t q[$];
  int checks = 0, passes = 0;

  // pulse vector order: {bg_start, spr_start, pix_start, frame_done, stage_abort}
  always @(negedge clk) begin
    logic [4:0] pul;
    exp_t e;
    pul = {bg_start, spr_start, pix_start, frame_done, stage_abort};
    if ((q.size() > 0 && q[0].cyc <= cyc) || pul != 5'b0) begin
      checks++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_event cyc=%0d got pul=%b row=%0d, want no event", cyc, pul, row_num);
      end else begin
        e = q.pop_front();
        if (e.cyc == cyc && pul === e.pul && row_num === 8'(e.row) && busy === e.busy &&
            late_count === 8'(e.lc) && frame_late === e.fl)
          passes++;
        else
          $display("FAIL event_at_%0d got cyc=%0d pul=%b row=%0d busy=%b lc=%0d fl=%b, want pul=%b row=%0d busy=%b lc=%0d fl=%b",
                   e.cyc, cyc, pul, row_num, busy, late_count, frame_late,
                   e.pul, e.row, e.busy, e.lc, e.fl);
      end
    end
  end

  // Reference model state: start cycle of current row, raw late swaps this frame.
  int s, lraw;
  int gbg, gspr, gp, gw;
  int lq[$];

  function automatic exp_t mk(int c, logic [4:0] p, int row, logic b, int l);
    exp_t e;
    e.cyc = c; e.pul = p; e.row = row; e.busy = b;
    e.lc = (l > 255) ? 255 : l;
    e.fl = (l > 0);
    return e;
  endfunction

  function automatic int nlate_before(int x);
    int n = 0;
    foreach (lq[i]) if (lq[i] < x) n++;
    return n;
  endfunction

  function automatic bit in_lq(int x);
    foreach (lq[i]) if (lq[i] == x) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge clk); #1;
    vbs = 0; vbe = 0; swp = 0; bgd = 0; sprd = 0; pixd = 0; rst = 0;
  endtask

  task automatic start_frame();
    vbe = 1;
    q.push_back(mk(cyc + 1, 5'b11000, 0, 1'b1, 0));
    lraw = 0;
    step();
    s = cyc;
  endtask

  task automatic gen_row();
    int a;
    gbg  = $urandom_range(0, 6);
    gspr = $urandom_range(0, 6);
    gp   = ((gbg > gspr) ? gbg : gspr) + 1 + $urandom_range(0, 5);
    gw   = gp + $urandom_range(0, 4);
    lq.delete();
    if ($urandom_range(0, 15) == 0) begin
      a = $urandom_range(0, gp - 1);
      lq.push_back(a);
      if (gp >= 2 && $urandom_range(0, 1) == 1) lq.push_back((a + 1 + $urandom_range(0, gp - 2)) % gp);
    end
  endtask

  // mode 0: normal, 1: vblank_start together with pix_done, 2: rst during FETCH
  task automatic run_row(int row, int mode);
    int fd, adv, last;
    bit late;
    fd   = (gbg > gspr) ? gbg : gspr;
    late = (lq.size() > 0);
    adv  = late ? gp : gw;
    if (mode != 2) q.push_back(mk(s + fd + 1, 5'b00100, row, 1'b1, lraw + nlate_before(fd + 1)));
    if (mode == 1) q.push_back(mk(s + gp + 1, 5'b00001, row, 1'b0, lraw + lq.size()));
    else if (mode == 2) q.push_back(mk(s + 2, 5'b00000, 0, 1'b0, 0));
    else begin
      lraw += lq.size();
      if (!late && gw > gp) q.push_back(mk(s + gp + 1, 5'b00000, row, 1'b0, lraw));
      if (row < 239) q.push_back(mk(s + adv + 1, 5'b11000, row + 1, 1'b1, lraw));
      else           q.push_back(mk(s + adv + 1, 5'b00010, row, 1'b0, lraw));
    end
    last = (mode == 1) ? gp : (mode == 2) ? 1 : adv;
    for (int off = 0; off <= last; off++) begin
      // stray dones / vblank_end land in states that must ignore them
      bgd  = (off == gbg) || (row % 4 == 1 && off == gp);
      sprd = (off == gspr) || (row % 4 == 2 && !late && gw > gp + 1 && off == gp + 1);
      pixd = (off == gp) || (row % 4 == 3 && off == 0);
      swp  = late ? in_lq(off) : (off == gw);
      vbe  = (row % 8 == 5 && off == 1);
      if (mode == 1 && off == gp) vbs = 1;
      if (mode == 2 && off == 1) rst = 1;
      step();
    end
    s = cyc;
    if (mode == 2) lraw = 0;
  endtask

  initial begin
    q.push_back(mk(1, 5'b00000, 0, 1'b0, 0));
    step();
    vbs = 1; bgd = 1; pixd = 1; swp = 1;
    step();
    step();

    // Frame A: full 240 rows with directed corner rows
    start_frame();
    for (int r = 0; r < 240; r++) begin
      gen_row();
      case (r)
        1: begin gbg = 3; gspr = 5; gp = 10; gw = 20; lq.delete(); end
        2: begin gbg = 3; gspr = 3; gp = 5;  gw = 9;  lq.delete(); end
        5: begin gbg = 1; gspr = 2; gp = 8;  gw = 8;  lq.delete(); lq.push_back(6); end
        7: begin gbg = 2; gspr = 0; gp = 6;  gw = 6;  lq.delete(); lq.push_back(1); lq.push_back(4); end
        default: ;
      endcase
      run_row(r, 0);
    end
    repeat (4) step();

    // Frame B: counter saturation, then abort in MIX of row 100
    start_frame();
    gbg = 1; gspr = 2; gp = 310; gw = 310; lq.delete();
    for (int i = 3; i < 303; i++) lq.push_back(i);
    run_row(0, 0);
    for (int r = 1; r < 100; r++) begin gen_row(); run_row(r, 0); end
    gbg = 1; gspr = 1; gp = 4; gw = 99; lq.delete();
    run_row(100, 1);
    repeat (3) step();

    // Frame C: late flag cleared at start, then reset during FETCH of row 50
    start_frame();
    for (int r = 0; r < 50; r++) begin
      gen_row();
      if (r == 10) begin lq.delete(); lq.push_back(0); end
      run_row(r, 0);
    end
    gbg = 3; gspr = 4; gp = 9; gw = 99; lq.delete();
    run_row(50, 2);
    repeat (3) step();

    // Frame D: restart after reset, abort during FETCH of row 3
    start_frame();
    for (int r = 0; r < 3; r++) begin gen_row(); run_row(r, 0); end
    vbs = 1;
    q.push_back(mk(cyc + 1, 5'b00001, 3, 1'b0, lraw));
    step();
    repeat (5) step();

    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL pending_events got %0d left, want 0 (next at cyc %0d)", q.size(), q[0].cyc);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
